// File: rtl/dmarb_pkg.sv
// Shared types and constants for the two-requester data memory arbiter.
package dmarb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDATA  = 2'd2
   } state_t;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a tie goes to the side not granted last.
module rr_pick2
   import dmarb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       valid
);

   always_comb begin
      valid  = |req;
      winner = PORT_C;
      if (req == 2'b11) begin
         winner = ~last;
      end else if (req[PORT_D]) begin
         winner = PORT_D;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU and debug/DMA requesters onto one single-ported data memory.
// Optional CPU stall cycle counter enabled by DMARB_STALL_COUNT_EN.
module data_mem_arbiter
   import dmarb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
`ifdef DMARB_STALL_COUNT_EN
   input  logic              stall_clr,
   output logic [15:0]       stall_cnt,
`endif
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_we,
   output logic              m_re,
   input  logic [DATA_W-1:0] m_rdata
);

   state_t            state_q, state_d;
   logic              win_q;
   logic              we_q;
   logic              last_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              pick_win;
   logic              pick_valid;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_pick2 u_pick (
      .req    ({d_req, c_req}),
      .last   (last_q),
      .winner (pick_win),
      .valid  (pick_valid)
   );

   assign sel_we    = (pick_win == PORT_D) ? d_we    : c_we;
   assign sel_addr  = (pick_win == PORT_D) ? d_addr  : c_addr;
   assign sel_wdata = (pick_win == PORT_D) ? d_wdata : c_wdata;

   // Requests are only sampled in IDLE; the pointer moves as the access is latched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         win_q   <= PORT_C;
         we_q    <= 1'b0;
         last_q  <= PORT_D;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_valid) begin
            win_q   <= pick_win;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            last_q  <= pick_win;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      c_gnt    = 1'b0;
      d_gnt    = 1'b0;
      c_rvalid = 1'b0;
      d_rvalid = 1'b0;
      m_we     = 1'b0;
      m_re     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            m_we = we_q;
            m_re = ~we_q;
            if (win_q == PORT_D) begin
               d_gnt = 1'b1;
            end else begin
               c_gnt = 1'b1;
            end
            state_d = we_q ? IDLE : RDATA;
         end
         RDATA: begin
            if (win_q == PORT_D) begin
               d_rvalid = 1'b1;
            end else begin
               c_rvalid = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign c_rdata = c_rvalid ? m_rdata : '0;
   assign d_rdata = d_rvalid ? m_rdata : '0;

   // A CPU read is only released by its data, not by its grant.
   assign c_stall = c_req & ~((c_gnt & we_q) | c_rvalid);

`ifdef DMARB_STALL_COUNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if (stall_clr) begin
         stall_cnt_q <= '0;
      end else if (c_stall && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed scoreboard bench for data_mem_arbiter; expected accesses and read data are
// queued as stimulus is driven and checked when the memory port or rvalid fires.
module tb_data_mem_arbiter;

   logic        clock;
   logic        reset;
   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
   logic [31:0] c_rdata, d_rdata;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_we, m_re;
`ifdef DMARB_STALL_COUNT_EN
   logic        stall_clr;
   logic [15:0] stall_cnt;
`endif

   typedef struct packed {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   acc_t        exp_q[$];
   logic [31:0] c_rd_q[$];
   logic [31:0] d_rd_q[$];
   acc_t        mon_a;
   logic [31:0] mem [0:255];

   int total = 0;
   int bad   = 0;

   data_mem_arbiter dut (
      .clock    (clock),
      .reset    (reset),
      .c_req    (c_req),
      .c_we     (c_we),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata),
      .c_gnt    (c_gnt),
      .c_rvalid (c_rvalid),
      .c_rdata  (c_rdata),
      .c_stall  (c_stall),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
`ifdef DMARB_STALL_COUNT_EN
      .stall_clr(stall_clr),
      .stall_cnt(stall_cnt),
`endif
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_we     (m_we),
      .m_re     (m_re),
      .m_rdata  (m_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory model: read data appears one cycle after m_re.
   always @(posedge clock) begin
      if (m_we) mem[m_addr[9:2]] <= m_wdata;
      if (m_re) m_rdata <= mem[m_addr[9:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_any(output logic [1:0] g, output int lat);
      g   = 2'b00;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clock);
         if (c_gnt === 1'b1 || d_gnt === 1'b1) begin
            g   = {c_gnt, d_gnt};
            lat = i;
            break;
         end
      end
   endtask

   task automatic push(input logic port, input logic we, input logic [31:0] a,
                       input logic [31:0] w);
      acc_t e;
      e.port  = port;
      e.we    = we;
      e.addr  = a;
      e.wdata = w;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clock) begin
      if (!reset) begin
         if (m_we || m_re) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_access", {m_addr[29:0], m_we, m_re}, 32'd0);
            end else begin
               mon_a = exp_q.pop_front();
               chk("acc_gnt", 32'({c_gnt, d_gnt}), mon_a.port ? 32'd1 : 32'd2);
               chk("acc_we", 32'({m_we, m_re}), mon_a.we ? 32'd2 : 32'd1);
               chk("acc_addr", m_addr, mon_a.addr);
               if (mon_a.we) chk("acc_wdata", m_wdata, mon_a.wdata);
            end
         end else begin
            chk("gnt_outside_access", 32'({c_gnt, d_gnt}), 32'd0);
         end
         chk("rvalid_onehot", 32'(c_rvalid & d_rvalid), 32'd0);
         if (c_rvalid) begin
            if (c_rd_q.size() == 0) chk("c_rvalid_unexpected", 32'(c_rvalid), 32'd0);
            else chk("c_rdata", c_rdata, c_rd_q.pop_front());
         end else begin
            chk("c_rdata_zero", c_rdata, 32'd0);
         end
         if (d_rvalid) begin
            if (d_rd_q.size() == 0) chk("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
            else chk("d_rdata", d_rdata, d_rd_q.pop_front());
         end else begin
            chk("d_rdata_zero", d_rdata, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] g;
      int         lat;
      reset   = 1'b1;
      c_req   = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      d_req   = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
`ifdef DMARB_STALL_COUNT_EN
      stall_clr = 1'b0;
`endif
      step();
      step();
      @(negedge clock);
      chk("rst_gnt", 32'({c_gnt, d_gnt}), 32'd0);
      chk("rst_mem_ctl", 32'({m_we, m_re}), 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      chk("rst_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
      step();
      reset = 1'b0;

      // CPU write: 2-cycle grant latency, 1-cycle grant pulse.
      step();
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
      push(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      wait_any(g, lat);
      chk("wr_gnt", 32'(g), 32'd2);
      chk("wr_lat", 32'(lat), 32'd2);
      chk("wr_m_we", 32'(m_we), 32'd1);
      chk("wr_stall_at_gnt", 32'(c_stall), 32'd0);
      step();
      c_req = 1'b0; c_we = 1'b0;
      @(negedge clock);
      chk("wr_gnt_pulse", 32'(c_gnt), 32'd0);
      chk("wr_stall_after", 32'(c_stall), 32'd0);

      // CPU read back: grant at 2, data at 3, stall held until data.
      step();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'h0;
      push(1'b0, 1'b0, 32'h10, 32'h0);
      c_rd_q.push_back(32'hDEADBEEF);
      wait_any(g, lat);
      chk("rd_gnt", 32'(g), 32'd2);
      chk("rd_lat", 32'(lat), 32'd2);
      chk("rd_stall_at_gnt", 32'(c_stall), 32'd1);
      step();
      @(negedge clock);
      chk("rd_rvalid", 32'(c_rvalid), 32'd1);
      chk("rd_c_rdata", c_rdata, 32'hDEADBEEF);
      chk("rd_d_rdata", d_rdata, 32'd0);
      chk("rd_stall_at_rvalid", 32'(c_stall), 32'd0);
      step();
      c_req = 1'b0;

      // D request pulsed while the CPU owns the memory is never latched.
      step();
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h20; c_wdata = 32'h11112222;
      push(1'b0, 1'b1, 32'h20, 32'h11112222);
      step();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h5555AAAA;
      @(negedge clock);
      chk("busy_c_gnt", 32'(c_gnt), 32'd1);
      step();
      d_req = 1'b0; c_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("busy_no_d_gnt", 32'(d_gnt), 32'd0);
      end
      chk("busy_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset during RDATA kills the read; pointer returns to D so the CPU wins a tie.
      step();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20; c_wdata = 32'h0;
      push(1'b0, 1'b0, 32'h20, 32'h0);
      wait_any(g, lat);
      chk("rst_rd_gnt", 32'(g), 32'd2);
      step();
      reset = 1'b1;
      c_req = 1'b0;
      @(negedge clock);
      chk("midrst_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
      chk("midrst_c_rdata", c_rdata, 32'd0);
      chk("midrst_mem_ctl", 32'({m_we, m_re}), 32'd0);
      chk("midrst_m_addr", m_addr, 32'd0);
      chk("midrst_m_wdata", m_wdata, 32'd0);
      chk("midrst_gnt", 32'({c_gnt, d_gnt}), 32'd0);
      step();
      reset = 1'b0;
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'hAAAA0001;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hBBBB0002;
      push(1'b0, 1'b1, 32'h40, 32'hAAAA0001);
      push(1'b1, 1'b1, 32'h44, 32'hBBBB0002);
      wait_any(g, lat);
      chk("tie_after_rst", 32'(g), 32'd2);
      step();
      c_req = 1'b0;
      wait_any(g, lat);
      chk("tie_second", 32'(g), 32'd1);
      step();
      d_req = 1'b0;

      // Continuous dual writes alternate C,D,...; one write per 2 cycles.
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h100; c_wdata = 32'hC0000000;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hD0000000;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) push(1'b0, 1'b1, c_addr, c_wdata);
         else push(1'b1, 1'b1, d_addr, d_wdata);
         wait_any(g, lat);
         chk("rr_order", 32'(g), (i % 2 == 0) ? 32'd2 : 32'd1);
         chk("rr_lat", 32'(lat), 32'd2);
         step();
         if (i % 2 == 0) begin
            c_addr = c_addr + 32'd4; c_wdata = c_wdata + 32'd1;
         end else begin
            d_addr = d_addr + 32'd4; d_wdata = d_wdata + 32'd1;
         end
      end
      c_req = 1'b0; d_req = 1'b0;

`ifdef DMARB_STALL_COUNT_EN
      // Make C the last grantee so a D read wins the following tie.
      step();
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'h0;
      push(1'b0, 1'b1, 32'h30, 32'h0);
      wait_any(g, lat);
      chk("sc_pre_gnt", 32'(g), 32'd2);
      step();
      c_req = 1'b0;
      stall_clr = 1'b1;
      step();
      stall_clr = 1'b0;
      @(negedge clock);
      chk("sc_cleared", 32'(stall_cnt), 32'd0);
      step();
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h104; c_wdata = 32'h0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h208; d_wdata = 32'h0;
      push(1'b1, 1'b0, 32'h208, 32'h0);
      push(1'b0, 1'b0, 32'h104, 32'h0);
      d_rd_q.push_back(32'hD0000002);
      c_rd_q.push_back(32'hC0000001);
      wait_any(g, lat);
      chk("sc_d_first", 32'(g), 32'd1);
      step();
      d_req = 1'b0;
      wait_any(g, lat);
      chk("sc_c_second", 32'(g), 32'd2);
      step();
      @(negedge clock);
      chk("sc_rvalid_stall", 32'(c_stall), 32'd0);
      step();
      c_req = 1'b0;
      @(negedge clock);
      chk("sc_count", 32'(stall_cnt), 32'd5);
      stall_clr = 1'b1;
      step();
      stall_clr = 1'b0;
      @(negedge clock);
      chk("sc_clr", 32'(stall_cnt), 32'd0);
`endif

      step();
      step();
      chk("end_acc_queue", 32'(exp_q.size()), 32'd0);
      chk("end_c_rd_queue", 32'(c_rd_q.size()), 32'd0);
      chk("end_d_rd_queue", 32'(d_rd_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
